// File: rtl/tc_pl_bus_pkg.sv
// Shared SPI bus definitions: mode/bit-order constants, width defaults and
// the slave FSM encoding. Used by both master and slave sides.
package tc_pl_bus_pkg;

    // Word width and synchronizer depth defaults shared with the master side
    localparam int SPI_W_DEF    = 8;
    localparam int SYNC_STG_DEF = 2;

    // Bus mode: CPOL=0, CPHA=0, MSB first
    localparam bit SPI_CPOL      = 1'b0;
    localparam bit SPI_CPHA      = 1'b0;
    localparam bit SPI_MSB_FIRST = 1'b1;

    // Slave frame state
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } spi_st_e;

    // Synchronized pin level plus its detected edges
    typedef struct packed {
        logic lvl;
        logic rise;
        logic fall;
    } sync_t;

endpackage

// File: rtl/tc_pl_bus_sync.sv
// Multi-flop synchronizer for one asynchronous pin, with an extra delay flop
// so rising/falling edges can be detected in the clk domain.
module tc_pl_bus_sync
    import tc_pl_bus_pkg::*;
#(
    parameter int   SYNC_STG = 2,
    parameter logic RST_VAL  = 1'b0
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  din,
    output sync_t sync
);

    logic [SYNC_STG-1:0] stg;
    logic                prev;

    // Synchronizer chain; prev holds the previous synchronized level
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stg  <= {SYNC_STG{RST_VAL}};
            prev <= RST_VAL;
        end else begin
            stg  <= {stg[SYNC_STG-2:0], din};
            prev <= stg[SYNC_STG-1];
        end
    end

    assign sync.lvl  = stg[SYNC_STG-1];
    assign sync.rise =  stg[SYNC_STG-1] & ~prev;
    assign sync.fall = ~stg[SYNC_STG-1] &  prev;

endmodule

// File: rtl/tc_pl_bus_spi_slave.sv
// Mode-0, MSB-first SPI slave oversampled by the system clock. Pins are
// synchronized, edges detected, and all frame/shift logic runs on clk.
// A one-word holding register feeds the transmit shifter; reloads happen at
// frame start and at every word boundary so multi-word frames stream.
module tc_pl_bus_spi_slave
    import tc_pl_bus_pkg::*;
#(
    parameter int SPI0_0   = SPI_W_DEF,
    parameter int SYNC_STG = SYNC_STG_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              CSN,
    input  logic              SCLK,
    input  logic              MOSI,
    output logic              MISO,
    output logic              tx_dreq,
    input  logic              tx_valid,
    input  logic [SPI0_0-1:0] tx_data,
    output logic              tx_idle,
    output logic [SPI0_0-1:0] rx_data,
    output logic              rx_valid,
    output logic              frm_err,
    output logic              tx_urun,
    input  logic              urun_clr
);

    localparam int CW = $clog2(SPI0_0);

    sync_t csn_s, sclk_s, mosi_s;

    spi_st_e           st, st_nxt;
    logic [CW-1:0]     cnt;
    logic [SPI0_0-1:0] hold, tx_sh, rx_sh;
    logic              hold_full;
    logic              start, stop, sck_r, sck_f, reload, word_done, accept;
    logic              sync_unused;

    tc_pl_bus_sync #(.SYNC_STG(SYNC_STG), .RST_VAL(1'b1)) u_sync_csn (
        .clk(clk), .rst(rst), .din(CSN), .sync(csn_s)
    );
    tc_pl_bus_sync #(.SYNC_STG(SYNC_STG), .RST_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst(rst), .din(SCLK), .sync(sclk_s)
    );
    tc_pl_bus_sync #(.SYNC_STG(SYNC_STG), .RST_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .rst(rst), .din(MOSI), .sync(mosi_s)
    );

    // Only edges of CSN/SCLK and the level of MOSI are consumed
    assign sync_unused = ^{csn_s.lvl, sclk_s.lvl, mosi_s.rise, mosi_s.fall};

    // Frame state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) st <= ST_IDLE;
        else      st <= st_nxt;
    end

    // Next state and per-cycle events; a CSN rising edge masks any SCLK edge
    always_comb begin
        st_nxt = st;
        start  = 1'b0;
        stop   = 1'b0;
        sck_r  = 1'b0;
        sck_f  = 1'b0;
        case (st)
            ST_IDLE: begin
                if (csn_s.fall) begin
                    st_nxt = ST_SHIFT;
                    start  = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (csn_s.rise) begin
                    st_nxt = ST_IDLE;
                    stop   = 1'b1;
                end else begin
                    sck_r = sclk_s.rise;
                    sck_f = sclk_s.fall;
                end
            end
            default: st_nxt = ST_IDLE;
        endcase
    end

    assign word_done = sck_r && (cnt == CW'(SPI0_0 - 1));
    assign reload    = start || (sck_f && (cnt == '0));
    assign accept    = tx_valid && !hold_full;

    // Bit counter: cleared at frame edges, wraps at each completed word
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                cnt <= '0;
        else if (start || stop)  cnt <= '0;
        else if (sck_r)          cnt <= word_done ? '0 : cnt + CW'(1);
    end

    // Receive shifter and word output; partial words are simply never published
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_sh    <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            frm_err  <= 1'b0;
        end else begin
            rx_valid <= word_done;
            frm_err  <= stop && (cnt != '0);
            if (sck_r) rx_sh <= {rx_sh[SPI0_0-2:0], mosi_s.lvl};
            if (word_done) rx_data <= {rx_sh[SPI0_0-2:0], mosi_s.lvl};
        end
    end

    // Transmit shifter: reload at frame start / word boundary, else shift on SCLK fall
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)        tx_sh <= '0;
        else if (reload) tx_sh <= hold_full ? hold : '0;
        else if (sck_f)  tx_sh <= {tx_sh[SPI0_0-2:0], 1'b0};
    end

    // Holding register: a load into an empty slot wins over a same-cycle reload
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold      <= '0;
            hold_full <= 1'b0;
        end else if (accept) begin
            hold      <= tx_data;
            hold_full <= 1'b1;
        end else if (reload) begin
            hold_full <= 1'b0;
        end
    end

    // Sticky underrun flag; software clear beats a coincident set
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                       tx_urun <= 1'b0;
        else if (urun_clr)              tx_urun <= 1'b0;
        else if (reload && !hold_full)  tx_urun <= 1'b1;
    end

    assign MISO    = (st == ST_SHIFT) ? tx_sh[SPI0_0-1] : 1'b0;
    assign tx_dreq = !hold_full;
    assign tx_idle = (st == ST_IDLE);

endmodule

// File: tb/tb_tc_pl_bus_spi_slave.sv
// Directed bench for the SPI slave. Stimulus pushes expected received words
// and MISO bits into queues; independent monitors pop and compare them.
module tb_tc_pl_bus_spi_slave;
    import tc_pl_bus_pkg::*;

    localparam int W  = 8;
    localparam int SS = 2;

    logic         clk = 1'b0, rst = 1'b0;
    logic         CSN = 1'b1, SCLK = 1'b0, MOSI = 1'b0;
    logic         tx_valid = 1'b0, urun_clr = 1'b0;
    logic [W-1:0] tx_data = '0;
    logic         MISO, tx_dreq, tx_idle, rx_valid, frm_err, tx_urun;
    logic [W-1:0] rx_data;

    int           n_chk = 0, n_pass = 0, err_pulses = 0, e0 = 0;
    logic [W-1:0] exp_rx_q[$];
    logic         exp_miso_q[$];
    bit           miso_en = 1'b0;

    tc_pl_bus_spi_slave #(.SPI0_0(W), .SYNC_STG(SS)) dut (
        .clk(clk), .rst(rst), .CSN(CSN), .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO),
        .tx_dreq(tx_dreq), .tx_valid(tx_valid), .tx_data(tx_data), .tx_idle(tx_idle),
        .rx_data(rx_data), .rx_valid(rx_valid), .frm_err(frm_err),
        .tx_urun(tx_urun), .urun_clr(urun_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", nm, act, exp);
    endtask

    // Received-word monitor
    always @(negedge clk) begin
        if (rx_valid) begin
            if (exp_rx_q.size() == 0) chk("rx_unexpected", 32'(rx_data), 32'hFFFF_FFFF);
            else chk("rx_data", 32'(rx_data), 32'(exp_rx_q.pop_front()));
        end
    end

    // frm_err pulse counter (counts high cycles, so a wide pulse shows up)
    always @(negedge clk) if (frm_err) err_pulses++;

    // MISO monitor: master samples on SCLK rise
    always @(posedge SCLK) begin
        if (!CSN && miso_en) begin
            if (exp_miso_q.size() == 0) chk("miso_extra", 32'(MISO), 32'hFFFF_FFFF);
            else chk("miso_bit", 32'(MISO), 32'(exp_miso_q.pop_front()));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic exp_miso(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) exp_miso_q.push_back(v[i]);
    endtask

    task automatic load_tx(input logic [W-1:0] d);
        int t = 0;
        while (!tx_dreq && t < 1000) begin
            @(negedge clk);
            t++;
        end
        chk("tx_dreq_wait", 32'(tx_dreq), 32'd1);
        tx_valid = 1'b1;
        tx_data  = d;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic spi_start();
        CSN = 1'b0;
        tick(8);
    endtask

    // clk/16 SCLK: MOSI changes with SCLK fall, 8 clk per half period
    task automatic spi_bits(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            MOSI = v[i];
            tick(8);
            SCLK = 1'b1;
            tick(8);
            SCLK = 1'b0;
        end
    endtask

    task automatic spi_end();
        tick(8);
        CSN = 1'b1;
        tick(8);
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_rx_data"},  32'(rx_data),  32'd0);
        chk({tag, "_rx_valid"}, 32'(rx_valid), 32'd0);
        chk({tag, "_frm_err"},  32'(frm_err),  32'd0);
        chk({tag, "_tx_urun"},  32'(tx_urun),  32'd0);
        chk({tag, "_miso"},     32'(MISO),     32'd0);
        chk({tag, "_tx_dreq"},  32'(tx_dreq),  32'd1);
        chk({tag, "_tx_idle"},  32'(tx_idle),  32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tick(3);
        chk_reset_outs("rst0");
        rst = 1'b1;
        tick(4);

        // Single word: TX 0xA5, RX 0x3C
        miso_en = 1'b1;
        load_tx(8'hA5);
        chk("a5_dreq_full", 32'(tx_dreq), 32'd0);
        e0 = err_pulses;
        exp_miso(32'hA5, 8);
        exp_rx_q.push_back(8'h3C);
        spi_start();
        chk("a5_busy", 32'(tx_idle), 32'd0);
        spi_bits(32'h3C, 8);
        spi_end();
        chk("a5_no_err", 32'(err_pulses - e0), 32'd0);
        chk("a5_rx_data", 32'(rx_data), 32'h3C);
        chk("a5_rx_pending", 32'(exp_rx_q.size()), 32'd0);

        // Two back-to-back words, second loaded mid-frame
        load_tx(8'h11);
        exp_miso(32'h1122, 16);
        exp_rx_q.push_back(8'hF0);
        exp_rx_q.push_back(8'h0F);
        fork
            begin
                spi_start();
                spi_bits(32'hF00F, 16);
                spi_end();
            end
            load_tx(8'h22);
        join
        chk("b2b_rx_data", 32'(rx_data), 32'h0F);
        chk("b2b_no_err", 32'(err_pulses - e0), 32'd0);
        chk("b2b_rx_pending", 32'(exp_rx_q.size()), 32'd0);

        // Underrun: empty holding register
        urun_clr = 1'b1;
        tick(1);
        urun_clr = 1'b0;
        chk("urun_cleared", 32'(tx_urun), 32'd0);
        exp_miso(32'h00, 8);
        exp_rx_q.push_back(8'h5A);
        spi_start();
        chk("urun_set", 32'(tx_urun), 32'd1);
        spi_bits(32'h5A, 8);
        spi_end();
        chk("urun_sticky", 32'(tx_urun), 32'd1);
        urun_clr = 1'b1;
        tick(1);
        urun_clr = 1'b0;
        chk("urun_clr", 32'(tx_urun), 32'd0);

        // Clear lands exactly on the frame-start reload (new underrun)
        exp_miso(32'h00, 8);
        exp_rx_q.push_back(8'h96);
        CSN = 1'b0;
        repeat (SS) @(posedge clk);
        @(negedge clk);
        urun_clr = 1'b1;
        @(negedge clk);
        urun_clr = 1'b0;
        chk("urun_clr_prio", 32'(tx_urun), 32'd0);
        chk("urun_prio_busy", 32'(tx_idle), 32'd0);
        tick(6);
        spi_bits(32'h96, 8);
        spi_end();
        chk("urun_word_end_set", 32'(tx_urun), 32'd1);

        // Partial frame: 5 bits then CSN high
        miso_en = 1'b0;
        e0 = err_pulses;
        spi_start();
        spi_bits(32'h16, 5);
        spi_end();
        chk("part_frm_err", 32'(err_pulses - e0), 32'd1);
        chk("part_rx_kept", 32'(rx_data), 32'h96);
        miso_en = 1'b1;
        load_tx(8'hC3);
        exp_miso(32'hC3, 8);
        exp_rx_q.push_back(8'h69);
        spi_start();
        spi_bits(32'h69, 8);
        spi_end();
        chk("part_next_rx", 32'(rx_data), 32'h69);
        chk("part_next_err", 32'(err_pulses - e0), 32'd1);

        // Reset mid-frame at bit 3
        miso_en = 1'b0;
        e0 = err_pulses;
        load_tx(8'h3E);
        spi_start();
        spi_bits(32'h5, 3);
        rst = 1'b0;
        tick(2);
        chk_reset_outs("rstmid");
        CSN  = 1'b1;
        SCLK = 1'b0;
        tick(2);
        rst = 1'b1;
        tick(4);
        chk("rstmid_no_err", 32'(err_pulses - e0), 32'd0);
        miso_en = 1'b1;
        load_tx(8'h81);
        exp_miso(32'h81, 8);
        exp_rx_q.push_back(8'h81);
        spi_start();
        spi_bits(32'h81, 8);
        spi_end();
        chk("rstmid_rx", 32'(rx_data), 32'h81);
        chk("rstmid_err_after", 32'(err_pulses - e0), 32'd0);

        // SCLK toggling while deselected is ignored
        e0 = err_pulses;
        for (int i = 0; i < 8; i++) begin
            SCLK = 1'b1;
            tick(4);
            chk("idle_miso", 32'(MISO), 32'd0);
            chk("idle_tx_idle", 32'(tx_idle), 32'd1);
            SCLK = 1'b0;
            tick(4);
        end
        chk("idle_no_err", 32'(err_pulses - e0), 32'd0);

        tick(20);
        chk("end_rx_pending", 32'(exp_rx_q.size()), 32'd0);
        chk("end_miso_pending", 32'(exp_miso_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
